// File: rtl/ins_fetch_pkg.sv
// Shared widths, state encoding and queue entry type for the instruction fetch stage.
// Also holds the PC legality rule used at the start of every word.
package ins_fetch_pkg;

    localparam int ADDR_W        = 10;
    localparam int PC_W          = 64;
    localparam int INS_W         = 32;
    localparam int BYTES_PER_INS = 4;
    localparam int DEPTH         = 2;
    localparam int IDX_W         = $clog2(BYTES_PER_INS);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [INS_W-1:0] data;
        logic [PC_W-1:0]  pc;
    } ins_entry_t;

    // A PC is usable only if word aligned and inside the program memory.
    function automatic logic pc_is_bad(input logic [PC_W-1:0] pc);
        return (pc[1:0] != 2'b00) || (pc[PC_W-1:ADDR_W] != '0);
    endfunction

endpackage

// File: rtl/ins_fetch_queue.sv
// DEPTH-entry in-order FIFO of {word, pc}; flush wins over push and pop.
// Head reads as zero while empty; a push into an empty queue shows up next cycle.
module ins_fetch_queue
    import ins_fetch_pkg::*;
(
    input  logic       clk,
    input  logic       rstN,
    input  logic       push,
    input  ins_entry_t push_entry,
    input  logic       pop,
    input  logic       flush,
    output ins_entry_t head,
    output logic       valid,
    output logic       full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    ins_entry_t       entries_q [DEPTH];
    ins_entry_t       entries_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_pop;
    logic             do_push;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop && (cnt_q != '0);
    assign do_push = push && ((cnt_q != CNT_W'(DEPTH)) || do_pop);

    always_comb begin
        entries_d = entries_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        cnt_d     = cnt_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) begin
                entries_d[wr_ptr_q] = push_entry;
                wr_ptr_d            = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            entries_q <= entries_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign valid = (cnt_q != '0);
    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign head  = valid ? entries_q[rd_ptr_q] : '0;

endmodule

// File: rtl/ins_fetch.sv
// Instruction fetch: one byte per cycle from program memory, assembled into
// little-endian 32-bit words tagged with their PC and queued for decode.
module ins_fetch
    import ins_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rstN,
    output logic [ADDR_W-1:0] raddr,
    input  logic [7:0]        rdata,
    input  logic              halt,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirectPc,
    output logic              insValid,
    input  logic              insReady,
    output logic [INS_W-1:0]  insData,
    output logic [PC_W-1:0]   insPc,
    output logic              isSingleNote,
    output logic              fetchFault,
    output fetch_state_e      dbgState
);

    fetch_state_e     state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
    logic [INS_W-1:0] asm_q, asm_d;
    logic             push;
    ins_entry_t       push_entry;
    ins_entry_t       head;
    logic             q_valid;
    logic             q_full;
    logic             pop;
    logic             space;

    // Handshake: a word transfers on a rising edge where insValid && insReady,
    // except during a redirect cycle, which discards the whole queue instead.
    assign pop   = q_valid && insReady && !redirect;
    assign space = !q_full || pop;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        push       = 1'b0;
        push_entry = '0;
        if (redirect) begin
            state_d    = ST_FETCH;
            pc_d       = redirectPc;
            byte_idx_d = '0;
            asm_d      = '0;
        end else if (!halt) begin
            case (state_q)
                ST_FETCH: begin
                    if (byte_idx_q == '0 && pc_is_bad(pc_q)) begin
                        state_d = ST_FAULT;
                    end else begin
                        asm_d[{byte_idx_q, 3'b000} +: 8] = rdata;
                        if (byte_idx_q == IDX_W'(BYTES_PER_INS - 1)) begin
                            if (space) begin
                                push            = 1'b1;
                                push_entry.data = asm_d;
                                push_entry.pc   = pc_q;
                                pc_d            = pc_q + PC_W'(BYTES_PER_INS);
                                byte_idx_d      = '0;
                            end else begin
                                // Keep byte_idx at 3 so raddr stays on the last byte.
                                state_d = ST_HOLD;
                            end
                        end else begin
                            byte_idx_d = byte_idx_q + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (space) begin
                        push            = 1'b1;
                        push_entry.data = asm_q;
                        push_entry.pc   = pc_q;
                        pc_d            = pc_q + PC_W'(BYTES_PER_INS);
                        byte_idx_d      = '0;
                        state_d         = ST_FETCH;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q    <= ST_FETCH;
            pc_q       <= '0;
            byte_idx_q <= '0;
            asm_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
        end
    end

    ins_fetch_queue u_queue (
        .clk        (clk),
        .rstN       (rstN),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect),
        .head       (head),
        .valid      (q_valid),
        .full       (q_full)
    );

    assign raddr        = pc_q[ADDR_W-1:0] + ADDR_W'(byte_idx_q);
    assign insValid     = q_valid;
    assign insData      = head.data;
    assign insPc        = head.pc;
    assign isSingleNote = q_valid && (head.data[30:23] == 8'h00);
    assign fetchFault   = (state_q == ST_FAULT);
    assign dbgState     = state_q;

endmodule

// File: tb/tb_ins_fetch.sv
// Bench for ins_fetch: directed steps from the test plan, then a randomized phase.
// A pop monitor compares every delivered word against the memory image and PC sequence.
module tb_ins_fetch;
    import ins_fetch_pkg::*;

    logic              clk;
    logic              rstN;
    logic [ADDR_W-1:0] raddr;
    logic [7:0]        rdata;
    logic              halt;
    logic              redirect;
    logic [PC_W-1:0]   redirectPc;
    logic              insValid;
    logic              insReady;
    logic [INS_W-1:0]  insData;
    logic [PC_W-1:0]   insPc;
    logic              isSingleNote;
    logic              fetchFault;
    fetch_state_e      dbgState;

    logic [7:0] mem [0:1023];
    int n_cmp  = 0;
    int n_bad  = 0;
    int n_pops = 0;
    logic [63:0] exp_pc;
    logic [31:0] mon_word;

    ins_fetch dut (
        .clk          (clk),
        .rstN         (rstN),
        .raddr        (raddr),
        .rdata        (rdata),
        .halt         (halt),
        .redirect     (redirect),
        .redirectPc   (redirectPc),
        .insValid     (insValid),
        .insReady     (insReady),
        .insData      (insData),
        .insPc        (insPc),
        .isSingleNote (isSingleNote),
        .fetchFault   (fetchFault),
        .dbgState     (dbgState)
    );

    assign rdata = mem[raddr];

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [63:0] pc);
        logic [9:0] a0, a1, a2, a3;
        a0 = pc[9:0];
        a1 = a0 + 10'd1;
        a2 = a0 + 10'd2;
        a3 = a0 + 10'd3;
        return {mem[a3], mem[a2], mem[a1], mem[a0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstN     = 1'b0;
        redirect = 1'b0;
        halt     = 1'b0;
        @(posedge clk);
        #1;
        rstN = 1'b1;
    endtask

    task automatic do_redirect(input logic [63:0] pc);
        redirect   = 1'b1;
        redirectPc = pc;
        tick();
        redirect   = 1'b0;
    endtask

    // ---------------- scoreboard: every pop versus the memory image ----------------
    always @(negedge clk) begin
        if (!rstN) begin
            exp_pc = 64'h0;
        end else begin
            if (!insValid) begin
                check("empty_data", insData, 0);
                check("empty_pc", insPc, 0);
                check("empty_note", isSingleNote, 0);
            end
            if (insValid && insReady && !redirect) begin
                mon_word = model_word(exp_pc);
                check("pop_legal", (insPc[1:0] == 2'b00) && (insPc[63:10] == '0), 1);
                check("pop_pc", insPc, exp_pc);
                check("pop_data", insData, mon_word);
                check("pop_note", isSingleNote, mon_word[30:23] == 8'h00);
                exp_pc = exp_pc + 64'd4;
                n_pops++;
            end
            if (redirect) begin
                exp_pc = redirectPc;
            end
        end
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        int pops_before;
        logic [63:0] rpc;

        rstN       = 1'b1;
        halt       = 1'b0;
        redirect   = 1'b0;
        redirectPc = '0;
        insReady   = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom_range(0, 255));
        mem[0] = 8'h78; mem[1] = 8'h56; mem[2] = 8'h34; mem[3] = 8'h12;
        mem[4] = 8'hEF; mem[5] = 8'hBE; mem[6] = 8'hAD; mem[7] = 8'hDE;
        #1 rstN = 1'b0;
        #1;
        check("rst_valid", insValid, 0);
        check("rst_data", insData, 0);
        check("rst_pc", insPc, 0);
        check("rst_note", isSingleNote, 0);
        check("rst_fault", fetchFault, 0);
        check("rst_raddr", raddr, 0);

        // First words and latency.
        insReady = 1'b1;
        do_reset();
        repeat (3) tick();
        check("lat_not_yet", insValid, 0);
        tick();
        check("w0_valid", insValid, 1);
        check("w0_data", insData, 32'h12345678);
        check("w0_pc", insPc, 0);
        repeat (3) tick();
        check("w1_gap", insValid, 0);
        tick();
        check("w1_valid", insValid, 1);
        check("w1_data", insData, 32'hDEADBEEF);
        check("w1_pc", insPc, 4);

        // Back-pressure: two queued, third held with raddr frozen.
        insReady = 1'b0;
        do_reset();
        repeat (15) tick();
        check("hold_raddr_a", raddr, 10'h00B);
        repeat (5) tick();
        check("hold_raddr_b", raddr, 10'h00B);
        check("hold_valid", insValid, 1);
        check("hold_head", insPc, 0);
        insReady = 1'b1;
        tick();
        check("drain_head1", insPc, 4);
        check("resume_raddr", raddr, 10'h00C);
        tick();
        check("drain_head2", insPc, 8);
        tick();
        check("drain_empty", insValid, 0);

        // Redirect mid-word with one entry queued.
        insReady = 1'b0;
        do_reset();
        repeat (6) tick();
        check("pre_redir_valid", insValid, 1);
        check("pre_redir_raddr", raddr, 10'h006);
        do_redirect(64'h40);
        check("redir_flush", insValid, 0);
        check("redir_raddr", raddr, 10'h040);
        insReady = 1'b1;
        repeat (3) tick();
        check("redir_lat", insValid, 0);
        tick();
        check("redir_valid", insValid, 1);
        check("redir_pc", insPc, 64'h40);

        // Misaligned PC faults, another redirect recovers.
        do_redirect(64'h3FE);
        check("fault_flush", insValid, 0);
        tick();
        check("fault_set", fetchFault, 1);
        check("fault_raddr_a", raddr, 10'h3FE);
        repeat (3) tick();
        check("fault_raddr_b", raddr, 10'h3FE);
        check("fault_novalid", insValid, 0);
        check("fault_stays", fetchFault, 1);
        do_redirect(64'h10);
        check("fault_clear", fetchFault, 0);
        repeat (3) tick();
        check("recover_lat", insValid, 0);
        tick();
        check("recover_valid", insValid, 1);
        check("recover_pc", insPc, 64'h10);

        // Last word of memory with a 3-cycle halt mid-word, then fault at 0x400.
        do_redirect(64'h3FC);
        repeat (2) tick();
        halt = 1'b1;
        repeat (3) tick();
        check("halt_raddr", raddr, 10'h3FE);
        check("halt_novalid", insValid, 0);
        halt = 1'b0;
        tick();
        check("halt_delay", insValid, 0);
        tick();
        check("top_valid", insValid, 1);
        check("top_pc", insPc, 64'h3FC);
        check("top_data", insData, model_word(64'h3FC));
        tick();
        check("wrap_fault", fetchFault, 1);
        check("wrap_empty", insValid, 0);

        // isSingleNote on both sides of bit 23.
        insReady = 1'b0;
        mem[10'h100] = 8'h00; mem[10'h101] = 8'h00; mem[10'h102] = 8'h00; mem[10'h103] = 8'h80;
        mem[10'h104] = 8'h00; mem[10'h105] = 8'h00; mem[10'h106] = 8'h80; mem[10'h107] = 8'h00;
        do_redirect(64'h100);
        repeat (4) tick();
        check("note1_data", insData, 32'h80000000);
        check("note1_flag", isSingleNote, 1);
        insReady = 1'b1;
        tick();
        check("note_empty", isSingleNote, 0);
        repeat (3) tick();
        check("note2_data", insData, 32'h00800000);
        check("note2_flag", isSingleNote, 0);

        // Asynchronous reset mid-word.
        insReady = 1'b0;
        do_redirect(64'h0);
        repeat (6) tick();
        check("pre_rst_valid", insValid, 1);
        #2 rstN = 1'b0;
        #1;
        check("arst_valid", insValid, 0);
        check("arst_data", insData, 0);
        check("arst_pc", insPc, 0);
        check("arst_note", isSingleNote, 0);
        check("arst_fault", fetchFault, 0);
        check("arst_raddr", raddr, 0);
        @(posedge clk);
        #1 rstN = 1'b1;
        repeat (3) tick();
        check("arst_lat", insValid, 0);
        tick();
        check("arst_first", insValid, 1);
        check("arst_first_pc", insPc, 0);

        // Randomized traffic against the memory image.
        rstN = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom_range(0, 255));
        do_reset();
        pops_before = n_pops;
        for (int c = 0; c < 1500; c++) begin
            insReady = ($urandom_range(0, 3) != 0);
            halt     = ($urandom_range(0, 9) == 0);
            redirect = ($urandom_range(0, 39) == 0);
            case ($urandom_range(0, 7))
                0:       rpc = 64'($urandom_range(0, 1023));
                1:       rpc = 64'h400 + 64'($urandom_range(0, 15) * 4);
                2:       rpc = 64'h3F0;
                default: rpc = {52'h0, 10'($urandom_range(0, 255) * 4), 2'b00} >> 2;
            endcase
            redirectPc = rpc;
            tick();
        end
        redirect = 1'b0;
        halt     = 1'b0;
        tick();
        check("rand_pops_seen", (n_pops - pops_before) > 50, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ins_fetch.md
Name: ins_fetch

Overview:
Instruction fetch stage sitting directly upstream of the CPU's instruction register (curIns). It reads the byte-wide program memory one byte per cycle, assembles 32-bit little-endian instruction words, and tags each word with its PC. Words are buffered in a 2-entry queue and handed to decode over a valid/ready handshake. The stage also supports PC redirect (branch/jump) and reports fetch faults.

Parameters:
ADDR_W, 10, memory byte-address width (1024-byte memory)
PC_W, 64, program counter width
DEPTH, 2, instruction queue entries

Ports:
clk  in  1  clock
rstN  in  1  reset, asynchronous, active-low
raddr  out  ADDR_W  byte address to program memory (combinational read)
rdata  in  8  byte returned for raddr in the same cycle
halt  in  1  freeze fetch progress
redirect  in  1  load new PC, flush queue and in-flight word
redirectPc  in  PC_W  new PC
insValid  out  1  queue head valid
insReady  in  1  decode accepts head
insData  out  32  head instruction word
insPc  out  PC_W  PC of head word
isSingleNote  out  1  insData[30:23] == 8'h00, qualified by insValid
fetchFault  out  1  fetch stopped on bad PC

Behaviour:
- Single clock domain, async active-low reset via rstN. Reset: pc=0, byteIdx=0, state FETCH, queue empty, insValid=0, insData=0, insPc=0, isSingleNote=0, fetchFault=0, raddr=0.
- raddr = pc[ADDR_W-1:0] + byteIdx (no carry beyond ADDR_W).
- Byte order: byteIdx 0 -> bits [7:0], 1 -> [15:8], 2 -> [23:16], 3 -> [31:24].
- States:
  - FETCH: each cycle with halt=0, capture rdata into the assembly register at byteIdx, then increment byteIdx. On the byteIdx=3 capture:
    - queue has space, or a pop happens this cycle: push {word, pc}, pc += 4, byteIdx = 0, stay in FETCH.
    - queue full with no pop: go to HOLD.
  - HOLD: assembled word retained; raddr frozen; push on the first cycle space exists, then pc += 4 and return to FETCH.
  - FAULT: no reads, no pushes; fetchFault=1; the queue still drains normally.
- PC check happens at the start of every word (byteIdx=0, in FETCH) before capture. A PC is bad if pc[1:0] != 0 or pc[PC_W-1:ADDR_W] != 0. A bad PC moves the stage to FAULT with no capture.
- halt=1: byteIdx, assembly register and state hold; raddr keeps being driven; the queue keeps draining.
- redirect=1 has the highest priority and overrides halt, HOLD and FAULT. On the next edge:
  - queue emptied; insValid=0 next cycle.
  - pc = redirectPc, byteIdx = 0, assembly register discarded, fetchFault cleared, state FETCH.
  - any pop in the redirect cycle is ignored.
- Queue rules:
  - in-order FIFO.
  - push and pop in the same cycle are legal, including when full or empty (an empty-queue push is not visible until the next cycle).
  - insData and insPc are 0 when the queue is empty.
- Latency: the first word is valid 4 cycles after reset release. Steady-state throughput is 1 word per 4 cycles.
- Address wrap: a word at pc 0x3FC completes; the next pc, 0x400, faults. There is no silent wrap.
- Reset mid-word or mid-HOLD returns everything to the reset values above, immediately (asynchronously).

Decomposition:
- Shared package holds: ADDR_W, PC_W, INS_W=32, BYTES_PER_INS=4, and the state enum {FETCH, HOLD, FAULT}.
- One sub-module: ins_fetch_queue, a DEPTH-entry FIFO of {insData, insPc} with push/pop/flush/full/empty.

Test Plan:
- mem[0..7] = 78 56 34 12 EF BE AD DE, insReady=1 -> insValid=1 at cycle 4 with insData=0x12345678, insPc=0; at cycle 8 insData=0xDEADBEEF, insPc=4.
- insReady=0 for 20 cycles -> two entries queued (pc 0, 4), third word held in HOLD, raddr constant = 0x00B. Then insReady=1 -> pops in order pc 0, 4, 8; fetch resumes at 0x00C.
- Redirect to 0x40 while byteIdx=2 and the queue holds one entry -> insValid=0 next cycle, raddr=0x040; next word popped has insPc=0x40.
- redirectPc=0x3FE -> fetchFault=1, insValid stays 0, raddr static. Then redirect to 0x10 -> fetchFault=0, next insPc=0x10.
- Redirect to 0x3FC -> word at 0x3FC delivered, then fetchFault=1 (pc 0x400). Same run: halt=1 for 3 cycles mid-word -> delivered word is unchanged, delivery delayed by 3 cycles.
- Word 0x80000000 (bits 30:23 zero) -> isSingleNote=1; word 0x00800000 -> isSingleNote=0. Assert rstN=0 mid-word -> all outputs 0 immediately; first word valid again 4 cycles after release.
